// File: rtl/mem_port_arbiter_if.sv
// Memory port arbiter bus: fetch port, load/store port and the
// unified memory port, grouped for the arbiter and its environment.
interface mem_port_arbiter_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  i_req;
  logic [ADDR_WIDTH-1:0] i_addr;
  logic                  i_gnt;
  logic                  i_rvalid;
  logic [31:0]           i_rdata;
  logic                  i_err;

  logic                  d_req;
  logic                  d_we;
  logic [ADDR_WIDTH-1:0] d_addr;
  logic [31:0]           d_wdata;
  logic [1:0]            d_size;
  logic                  d_lock;
  logic                  d_gnt;
  logic                  d_rvalid;
  logic [31:0]           d_rdata;
  logic                  d_err;

  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_ra;
  logic [ADDR_WIDTH-1:0] mem_wa;
  logic [31:0]           mem_wd;
  logic [1:0]            mem_rs;
  logic [1:0]            mem_ws;
  logic [31:0]           mem_rd;

  modport master (
    output i_req, i_addr,
    output d_req, d_we, d_addr, d_wdata, d_size, d_lock,
    output mem_rd,
    input  i_gnt, i_rvalid, i_rdata, i_err,
    input  d_gnt, d_rvalid, d_rdata, d_err,
    input  mem_we, mem_ra, mem_wa, mem_wd, mem_rs, mem_ws
  );

  modport slave (
    input  i_req, i_addr,
    input  d_req, d_we, d_addr, d_wdata, d_size, d_lock,
    input  mem_rd,
    output i_gnt, i_rvalid, i_rdata, i_err,
    output d_gnt, d_rvalid, d_rdata, d_err,
    output mem_we, mem_ra, mem_wa, mem_wd, mem_rs, mem_ws
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Unified-memory arbiter for fetch (I) and load/store (D) ports with
// D priority, I starvation guard, locked RMW sequences and alignment checks.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int MAX_WAIT   = 4,
  parameter int CNT_WIDTH  = 8
) (
  input logic clk,
  input logic rst,
  mem_port_arbiter_if.slave bus
);

  typedef enum logic {ARB, LOCKED} state_t;

  state_t                state, state_nxt;
  logic [CNT_WIDTH-1:0]  wait_cnt, cnt_nxt;
  logic                  prio, prio_nxt;
  logic                  i_gnt, d_gnt;
  logic                  i_mis, d_mis;
  logic                  i_ok, d_ok;
  logic [ADDR_WIDTH-1:0] addr;
  logic                  i_rvalid, d_rvalid;
  logic                  i_err, d_err;
  logic [31:0]           i_rdata, d_rdata;

  assign i_mis = bus.i_addr[1:0] != 2'b00;

  always_comb begin
    d_mis = 1'b0;
    case (bus.d_size)
      2'd1:    d_mis = 1'b0;
      2'd2:    d_mis = bus.d_addr[0];
      default: d_mis = bus.d_addr[1:0] != 2'b00;
    endcase
  end

  always_comb begin
    i_gnt     = 1'b0;
    d_gnt     = 1'b0;
    state_nxt = state;
    cnt_nxt   = wait_cnt;
    prio_nxt  = prio;
    if (!rst) begin
      unique case (state)
        ARB: begin
          if (prio && bus.i_req)  i_gnt = 1'b1;
          else if (bus.d_req)     d_gnt = 1'b1;
          else if (bus.i_req)     i_gnt = 1'b1;
        end
        LOCKED: d_gnt = bus.d_req;
        default: ;
      endcase
    end
    if (d_gnt)
      state_nxt = bus.d_lock ? LOCKED : ARB;
    if (i_gnt || !bus.i_req)
      cnt_nxt = '0;
    else if (wait_cnt != '1)
      cnt_nxt = wait_cnt + 1'b1;
    if (i_gnt)
      prio_nxt = 1'b0;
    else if (bus.i_req && cnt_nxt == CNT_WIDTH'(MAX_WAIT))
      prio_nxt = 1'b1;
  end

  assign i_ok = i_gnt && !i_mis;
  assign d_ok = d_gnt && !d_mis;

  always_comb begin
    addr       = '0;
    bus.mem_we = 1'b0;
    bus.mem_rs = 2'd0;
    bus.mem_ws = 2'd0;
    bus.mem_wd = '0;
    unique case (1'b1)
      i_ok: begin
        addr       = bus.i_addr;
        bus.mem_wd = bus.d_wdata;
      end
      d_ok: begin
        addr       = bus.d_addr;
        bus.mem_rs = bus.d_size;
        bus.mem_ws = bus.d_size;
        bus.mem_wd = bus.d_wdata;
        bus.mem_we = bus.d_we;
      end
      default: ;
    endcase
  end

  assign bus.mem_ra = addr;
  assign bus.mem_wa = addr;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ARB;
      wait_cnt <= '0;
      prio     <= 1'b0;
      i_rvalid <= 1'b0;
      i_err    <= 1'b0;
      i_rdata  <= '0;
      d_rvalid <= 1'b0;
      d_err    <= 1'b0;
      d_rdata  <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= cnt_nxt;
      prio     <= prio_nxt;
      i_rvalid <= i_gnt;
      i_err    <= i_gnt && i_mis;
      d_rvalid <= d_gnt;
      d_err    <= d_gnt && d_mis;
      if (i_gnt)
        i_rdata <= i_mis ? '0 : bus.mem_rd;
      // stores and rejected accesses answer with zero data
      if (d_gnt)
        d_rdata <= (d_mis || bus.d_we) ? '0 : bus.mem_rd;
    end
  end

  assign bus.i_gnt    = i_gnt;
  assign bus.d_gnt    = d_gnt;
  assign bus.i_rvalid = i_rvalid;
  assign bus.i_err    = i_err;
  assign bus.i_rdata  = i_rdata;
  assign bus.d_rvalid = d_rvalid;
  assign bus.d_err    = d_err;
  assign bus.d_rdata  = d_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a byte memory model and
// a response scoreboard fed at each grant.
module tb_mem_port_arbiter;

  logic clk;
  logic rst;
  mem_port_arbiter_if #(.ADDR_WIDTH(32)) bus ();

  mem_port_arbiter #(
    .ADDR_WIDTH(32),
    .MAX_WAIT(4),
    .CNT_WIDTH(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          dport;
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  rsp_t q[$];
  int   tests = 0;
  int   fails = 0;

  logic [7:0] mem [0:255];

  function automatic int nb(input logic [1:0] s);
    return (s == 2'd0) ? 4 : int'(s);
  endfunction

  function automatic logic [31:0] mread(input logic [7:0] a,
                                        input logic [1:0] s);
    logic [31:0] v;
    v = '0;
    for (int k = 0; k < 4; k++)
      if (k < nb(s)) v[8*k +: 8] = mem[a + 8'(k)];
    return v;
  endfunction

  function automatic logic mis(input logic [31:0] a,
                               input logic [1:0] s);
    if (s == 2'd1) return 1'b0;
    if (s == 2'd2) return a[0];
    return a[1:0] != 2'b00;
  endfunction

  assign bus.mem_rd = mread(bus.mem_ra[7:0], bus.mem_rs);

  always @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < 256; k++) mem[k] <= 8'h00;
      mem[8'h00] <= 8'h13; mem[8'h01] <= 8'h00;
      mem[8'h04] <= 8'h6f; mem[8'h05] <= 8'h10;
      mem[8'h08] <= 8'hb7; mem[8'h09] <= 8'h0a;
      mem[8'h10] <= 8'h44; mem[8'h11] <= 8'h33;
      mem[8'h12] <= 8'h22; mem[8'h13] <= 8'h11;
      mem[8'h20] <= 8'hef; mem[8'h21] <= 8'hbe;
      mem[8'h22] <= 8'had; mem[8'h23] <= 8'hde;
    end else if (bus.mem_we) begin
      for (int k = 0; k < 4; k++)
        if (k < nb(bus.mem_ws))
          mem[bus.mem_wa[7:0] + 8'(k)] <= bus.mem_wd[8*k +: 8];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    bus.i_req   = 1'b0;
    bus.i_addr  = '0;
    bus.d_req   = 1'b0;
    bus.d_we    = 1'b0;
    bus.d_addr  = '0;
    bus.d_wdata = '0;
    bus.d_size  = 2'd0;
    bus.d_lock  = 1'b0;
  endtask

  task automatic dreq(input logic we, input logic [31:0] a,
                      input logic [31:0] wd, input logic [1:0] s,
                      input logic lk);
    bus.d_req   = 1'b1;
    bus.d_we    = we;
    bus.d_addr  = a;
    bus.d_wdata = wd;
    bus.d_size  = s;
    bus.d_lock  = lk;
  endtask

  task automatic cyc(input logic ei, input logic ed, input logic ewe,
                     input logic [31:0] era, input logic [31:0] ewd);
    rsp_t e;
    rsp_t r;
    @(negedge clk);
    chk("i_gnt", 32'(bus.i_gnt), 32'(ei));
    chk("d_gnt", 32'(bus.d_gnt), 32'(ed));
    chk("mem_we", 32'(bus.mem_we), 32'(ewe));
    chk("mem_ra", bus.mem_ra, era);
    chk("mem_wa", bus.mem_wa, era);
    chk("mem_wd", bus.mem_wd, ewd);
    if (ei) begin
      e.dport = 1'b0;
      e.err   = mis(bus.i_addr, 2'd0);
      e.rdata = e.err ? 32'h0 : mread(bus.i_addr[7:0], 2'd0);
      q.push_back(e);
    end
    if (ed) begin
      e.dport = 1'b1;
      e.err   = mis(bus.d_addr, bus.d_size);
      e.rdata = (e.err || bus.d_we) ? 32'h0
              : mread(bus.d_addr[7:0], bus.d_size);
      q.push_back(e);
    end
    @(posedge clk);
    #1;
    if (q.size() > 0) begin
      r = q.pop_front();
      if (r.dport) begin
        chk("d_rvalid", 32'(bus.d_rvalid), 32'd1);
        chk("d_rdata", bus.d_rdata, r.rdata);
        chk("d_err", 32'(bus.d_err), 32'(r.err));
        chk("i_rvalid_idle", 32'(bus.i_rvalid), 32'd0);
      end else begin
        chk("i_rvalid", 32'(bus.i_rvalid), 32'd1);
        chk("i_rdata", bus.i_rdata, r.rdata);
        chk("i_err", 32'(bus.i_err), 32'(r.err));
        chk("d_rvalid_idle", 32'(bus.d_rvalid), 32'd0);
      end
    end else begin
      chk("i_rvalid_none", 32'(bus.i_rvalid), 32'd0);
      chk("d_rvalid_none", 32'(bus.d_rvalid), 32'd0);
      chk("i_err_none", 32'(bus.i_err), 32'd0);
      chk("d_err_none", 32'(bus.d_err), 32'd0);
    end
  endtask

  initial begin
    idle();
    rst = 1'b1;
    // requests during reset must not be granted
    bus.i_req = 1'b1;
    dreq(1'b1, 32'h10, 32'hffff_ffff, 2'd0, 1'b1);
    cyc(0, 0, 0, 32'h0, 32'h0);
    cyc(0, 0, 0, 32'h0, 32'h0);
    chk("rst_i_rdata", bus.i_rdata, 32'h0);
    chk("rst_d_rdata", bus.d_rdata, 32'h0);
    rst = 1'b0;
    idle();
    cyc(0, 0, 0, 32'h0, 32'h0);
    cyc(0, 0, 0, 32'h0, 32'h0);

    // contention: D wins, I follows once D drops
    bus.i_req  = 1'b1;
    bus.i_addr = 32'h4;
    dreq(1'b0, 32'h10, 32'h0, 2'd0, 1'b0);
    cyc(0, 1, 0, 32'h10, 32'h0);
    chk("cont_d_rdata", bus.d_rdata, 32'h1122_3344);
    bus.d_req = 1'b0;
    cyc(1, 0, 0, 32'h4, 32'h0);
    chk("cont_i_rdata", bus.i_rdata, 32'h0000_106f);
    idle();
    cyc(0, 0, 0, 32'h0, 32'h0);

    // starvation: four D grants, then I, then D again
    bus.i_req  = 1'b1;
    bus.i_addr = 32'h8;
    dreq(1'b0, 32'h10, 32'h0, 2'd0, 1'b0);
    repeat (4) cyc(0, 1, 0, 32'h10, 32'h0);
    cyc(1, 0, 0, 32'h8, 32'h0);
    cyc(0, 1, 0, 32'h10, 32'h0);
    idle();
    cyc(0, 0, 0, 32'h0, 32'h0);

    // locked RMW holds I off even after its priority is raised
    bus.i_req  = 1'b1;
    bus.i_addr = 32'h0;
    dreq(1'b0, 32'h20, 32'h0, 2'd0, 1'b1);
    cyc(0, 1, 0, 32'h20, 32'h0);
    chk("lock_rdata", bus.d_rdata, 32'hdead_beef);
    bus.d_req = 1'b0;
    repeat (5) cyc(0, 0, 0, 32'h0, 32'h0);
    dreq(1'b1, 32'h20, 32'h0000_00a5, 2'd1, 1'b0);
    cyc(0, 1, 1, 32'h20, 32'h0000_00a5);
    dreq(1'b0, 32'h20, 32'h0, 2'd0, 1'b0);
    cyc(1, 0, 0, 32'h0, 32'h0);
    bus.i_req = 1'b0;
    cyc(0, 1, 0, 32'h20, 32'h0);
    chk("rmw_rdata", bus.d_rdata, 32'hdead_bea5);
    idle();
    cyc(0, 0, 0, 32'h0, 32'h0);

    // alignment
    dreq(1'b0, 32'h22, 32'h0, 2'd0, 1'b0);
    cyc(0, 1, 0, 32'h0, 32'h0);
    chk("mis_err", 32'(bus.d_err), 32'd1);
    chk("mis_rdata", bus.d_rdata, 32'h0);
    dreq(1'b1, 32'h21, 32'h0000_ffff, 2'd2, 1'b0);
    cyc(0, 1, 0, 32'h0, 32'h0);
    dreq(1'b0, 32'h20, 32'h0, 2'd0, 1'b0);
    cyc(0, 1, 0, 32'h20, 32'h0);
    chk("mis_nowrite", bus.d_rdata, 32'hdead_bea5);
    dreq(1'b0, 32'h10, 32'h0, 2'd3, 1'b0);
    cyc(0, 1, 0, 32'h10, 32'h0);
    chk("tri_rdata", bus.d_rdata, 32'h0022_3344);
    dreq(1'b0, 32'h12, 32'h0, 2'd2, 1'b0);
    cyc(0, 1, 0, 32'h12, 32'h0);
    chk("half_rdata", bus.d_rdata, 32'h0000_1122);
    dreq(1'b0, 32'h13, 32'h0, 2'd1, 1'b0);
    cyc(0, 1, 0, 32'h13, 32'h0);
    chk("byte_rdata", bus.d_rdata, 32'h0000_0011);
    idle();
    bus.i_req  = 1'b1;
    bus.i_addr = 32'h3;
    cyc(1, 0, 0, 32'h0, 32'h0);
    chk("i_mis_err", 32'(bus.i_err), 32'd1);
    idle();
    cyc(0, 0, 0, 32'h0, 32'h0);

    // reset right after a locked grant drops lock and response
    dreq(1'b0, 32'h10, 32'h0, 2'd0, 1'b1);
    cyc(0, 1, 0, 32'h10, 32'h0);
    idle();
    bus.i_req  = 1'b1;
    bus.i_addr = 32'h4;
    rst = 1'b1;
    cyc(0, 0, 0, 32'h0, 32'h0);
    chk("rst_mid_rdata", bus.d_rdata, 32'h0);
    rst = 1'b0;
    cyc(1, 0, 0, 32'h4, 32'h0);
    idle();
    cyc(0, 0, 0, 32'h0, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
